bcd_to_bin_seq: RTL and testbench

Sequential packed-BCD to binary converter. It accepts a DIGITS-digit packed BCD word through a valid/ready handshake and converts it one digit per cycle, most significant digit first, using `acc = acc*10 + digit`. The result is presented through a second valid/ready handshake. It is the decode-side counterpart to the team's combinational 4-bit binary-to-BCD converter, and sits between BCD display/keypad data paths and binary arithmetic logic.

---
 rtl/bcd_to_bin_seq.sv | 145 ++++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_seq
//
// Sequential packed-BCD to binary converter. A DIGITS-digit packed BCD word
// is accepted through an input handshake, converted most significant digit
// first (one digit per clock, acc = acc*10 + digit, with the x10 built as
// (acc<<3) + (acc<<1)), and the result is offered through an output
// handshake. A digit above 9 anywhere in the word sets a sticky error for
// that transaction; the reported binary value is then forced to zero.
//
// Handshake semantics (both sides): a transfer happens on the rising clock
// edge where valid and ready are both 1. in_ready is high only in IDLE and
// out_valid only in DONE; both decode from the state register alone, so no
// output depends combinationally on in_valid or out_ready. While out_valid
// is high, bin_out and err stay stable until the transfer edge.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (forces IDLE, clears all)
//   in_valid   in   bcd_in carries a word
//   in_ready   out  block can accept a word (IDLE)
//   bcd_in     in   packed BCD, digit k = bcd_in[4k+3:4k], digit DIGITS-1 MSD
//   out_valid  out  bin_out/err carry a result (DONE)
//   out_ready  in   downstream accepts the result
//   bin_out    out  binary value (0 when err or when out_valid is low)
//   err        out  some digit of the word was > 9 (0 when out_valid is low)
// ---------------------------------------------------------------------------
module bcd_to_bin_seq #(
    parameter int DIGITS = 4,
    parameter int BW     = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BW-1:0]         bin_out,
    output logic                  err
);

    // Counter needs at least one bit even for a single-digit converter.
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SW = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [SW-1:0]  sr_q,    sr_d;
    logic [BW-1:0]  acc_q,   acc_d;
    logic           err_q,   err_d;
    logic [CW-1:0]  cnt_q,   cnt_d;

    logic [3:0]     digit;
    logic [BW-1:0]  digit_ext;
    logic [BW-1:0]  acc_x10;

    // The most significant unprocessed digit always sits at the top of the
    // shift register; the register shifts left by one digit per CONV cycle.
    assign digit     = sr_q[SW-1 -: 4];
    assign digit_ext = BW'(digit);

    // acc*10 as shift-add, modulo 2^BW.
    assign acc_x10   = (acc_q << 3) + (acc_q << 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sr_d    = bcd_in;
                    acc_d   = '0;
                    err_d   = 1'b0;
                    cnt_d   = CW'(DIGITS - 1);
                    state_d = ST_CONV;
                end
            end

            ST_CONV: begin
                // Invalid digits are still accumulated; the value is
                // discarded at the output, so wrap-around is harmless.
                acc_d = acc_x10 + digit_ext;
                if (digit > 4'd9) begin
                    err_d = 1'b1;
                end
                sr_d  = sr_q << 4;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only, result gated by DONE.
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign bin_out   = (out_valid && !err_q) ? acc_q : '0;
    assign err       = out_valid && err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_bin_seq
//
// Directed bench for bcd_to_bin_seq (DIGITS=4, BW=14). Drivers push the
// expected {err, bin_out} into exp_q when a word is offered at an edge where
// the block is ready; an independent monitor on the falling edge pops and
// compares on every output transfer, and also checks latency, output
// stability under backpressure, output qualification and reset values.
// ---------------------------------------------------------------------------
module tb_bcd_to_bin_seq;

    localparam int DIGITS = 4;
    localparam int BW     = 14;
    localparam int W      = BW + 1;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic              clk       = 1'b0;
    logic              rst_n     = 1'b1;
    logic              in_valid  = 1'b0;
    logic [15:0]       bcd_in    = 16'h0;
    logic              out_ready = 1'b1;
    logic              in_ready;
    logic              out_valid;
    logic [BW-1:0]     bin_out;
    logic              err;

    always #5 clk = ~clk;

    bcd_to_bin_seq #(
        .DIGITS (DIGITS),
        .BW     (BW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .err       (err)
    );

    // out_ready policy: forced low, random (mostly high), or held high.
    bit hold_rdy = 1'b0;
    bit rand_rdy = 1'b0;

    always @(posedge clk) begin
        #2;
        if (hold_rdy)      out_ready = 1'b0;
        else if (rand_rdy) out_ready = ($urandom_range(0, 7) != 0);
        else               out_ready = 1'b1;
    end

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [W-1:0]  exp_q[$];
    int            lat_q[$];
    int            errors = 0;
    int            checks = 0;
    int            ncyc   = 0;
    logic          prev_ov  = 1'b0;
    logic [W-1:0]  prev_out = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ------------------------------------------------------------------
    // Monitor: samples on the falling edge, away from the active edge.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        int           a;
        ncyc++;
        if (!rst_n) begin
            chk("reset_in_ready",  32'(in_ready),  32'd1);
            chk("reset_out_valid", 32'(out_valid), 32'd0);
            chk("reset_outputs",   32'({err, bin_out}), 32'd0);
            prev_ov = 1'b0;
        end else begin
            if (!out_valid) begin
                chk("qualified_zero", 32'({err, bin_out}), 32'd0);
            end else begin
                chk("in_ready_low_in_done", 32'(in_ready), 32'd0);
            end
            // The word is accepted at the rising edge after this sample.
            if (in_valid && in_ready) begin
                lat_q.push_back(ncyc);
            end
            // Accept seen at sample n -> out_valid first seen at n+DIGITS+1.
            if (out_valid && !prev_ov) begin
                if (lat_q.size() == 0) begin
                    fail_now("latency_no_accept");
                end else begin
                    a = lat_q.pop_front();
                    chk("latency", 32'(ncyc - a), 32'(DIGITS + 1));
                end
            end
            if (out_valid && prev_ov) begin
                chk("hold_stable", 32'({err, bin_out}), 32'(prev_out));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    e = exp_q.pop_front();
                    chk("result", 32'({err, bin_out}), 32'(e));
                end
            end
            prev_ov  = out_valid;
            prev_out = {err, bin_out};
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks (called aligned to 1 time unit after a rising edge)
    // ------------------------------------------------------------------
    task automatic send(input logic [15:0] bcd, input logic [BW-1:0] eb, input logic ee);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        bcd_in   = bcd;
        for (int t = 0; t < 1000 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({ee, eb});
                done = 1'b1;
            end
        end
        if (!done) fail_now("send_timeout");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 2000 && exp_q.size() != 0; t++) begin
            @(negedge clk);
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [15:0]   dir_in  [6] = '{16'h1234, 16'h0000, 16'h9999, 16'h0015, 16'h12A4, 16'h0042};
    logic [BW-1:0] dir_bin [6] = '{14'd1234, 14'd0,    14'd9999, 14'd15,   14'd0,    14'd42};
    logic          dir_err [6] = '{1'b0,     1'b0,     1'b0,     1'b0,     1'b1,     1'b0};

    initial begin
        logic [15:0] w;

        // Reset held for 3 cycles with random inputs.
        #1;
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom_range(0, 1));
            bcd_in   = 16'($urandom);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;

        // Basic conversions and invalid-digit handling.
        for (int i = 0; i < 6; i++) begin
            send(dir_in[i], dir_bin[i], dir_err[i]);
        end
        drain();

        // Backpressure: result held, other data refused.
        hold_rdy = 1'b1;
        send(16'h0789, 14'd789, 1'b0);
        in_valid = 1'b1;
        bcd_in   = 16'h1111;
        repeat (10) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        hold_rdy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Reset two cycles into a conversion aborts it.
        send(16'h5555, 14'd5555, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        lat_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        chk("post_reset_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        send(16'h0003, 14'd3, 1'b0);
        drain();

        // Single low digit.
        for (int d = 0; d < 10; d++) begin
            send({12'h000, 4'(d)}, BW'(d), 1'b0);
        end
        drain();

        // All valid 4-digit words, out_ready randomly toggled.
        rand_rdy = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            w = {4'(i / 1000), 4'((i / 100) % 10), 4'((i / 10) % 10), 4'(i % 10)};
            send(w, BW'(i), 1'b0);
        end
        drain();
        rand_rdy = 1'b0;

        chk("no_pending_accepts", 32'(lat_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit.
    initial begin
        #2_000_000;
        fail_now("watchdog");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
